// File: rtl/cut_bank_pkg.sv
// cut_pkg: shared types and constants for the cut_bank rectangle cutter.
//   pixel_t    : {colour, t}, t=1 means opaque
//   rect_cfg_t : one rectangle slot (inclusive bounds, enable, invert[, blink])
// Optional feature macro: CUT_BLINK_EN adds a per-slot blink bit.
package cut_pkg;

  localparam int   COORD_W     = 10;
  localparam int   COLOR_W     = 9;
  localparam logic T_OPAQUE    = 1'b1;
  localparam logic T_CLEAR     = 1'b0;
  localparam int   BLINK_CNT_W = 6;

  typedef struct packed {
    logic [COLOR_W-1:0] colour;
    logic               t;
  } pixel_t;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic               en;
    logic               inv;
`ifdef CUT_BLINK_EN
    logic               blink;
`endif
  } rect_cfg_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  // Slot index width; a single-slot bank still carries a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cut_bank_if.sv
// cut_bank_if: config write port, frame/pixel input and pixel output of cut_bank.
//   master : driver side (compositor / bench)
//   slave  : cut_bank side
// Optional feature macro: CUT_BLINK_EN adds cfg_blink.
interface cut_bank_if #(parameter int NUM_RECT = 4);
  import cut_pkg::*;

  localparam int IDX_W = idx_w(NUM_RECT);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [IDX_W-1:0]   cfg_idx;
  logic [COORD_W-1:0] cfg_x1;
  logic [COORD_W-1:0] cfg_y1;
  logic [COORD_W-1:0] cfg_x2;
  logic [COORD_W-1:0] cfg_y2;
  logic               cfg_en;
  logic               cfg_inv;
`ifdef CUT_BLINK_EN
  logic               cfg_blink;
`endif
  logic               frame_start;
  logic               pix_valid;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic [COLOR_W:0]   layer_in;
  logic               out_valid;
  logic [COLOR_W:0]   rgbt_out;

  modport master (
`ifdef CUT_BLINK_EN
    output cfg_blink,
`endif
    output cfg_valid, cfg_idx, cfg_x1, cfg_y1, cfg_x2, cfg_y2, cfg_en, cfg_inv,
    output frame_start, pix_valid, X, Y, layer_in,
    input  cfg_ready, out_valid, rgbt_out
  );

  modport slave (
`ifdef CUT_BLINK_EN
    input  cfg_blink,
`endif
    input  cfg_valid, cfg_idx, cfg_x1, cfg_y1, cfg_x2, cfg_y2, cfg_en, cfg_inv,
    input  frame_start, pix_valid, X, Y, layer_in,
    output cfg_ready, out_valid, rgbt_out
  );

endinterface

// File: rtl/cut_bank_rect_hit.sv
// rect_hit: combinational per-slot test.
//   cfg       : active slot configuration
//   x, y      : current pixel coordinate
//   blink_off : (CUT_BLINK_EN only) blink phase in which blinking slots are suppressed
//   cut       : slot wants this pixel made transparent
module rect_hit
  import cut_pkg::*;
(
  input  rect_cfg_t          cfg,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
`ifdef CUT_BLINK_EN
  input  logic               blink_off,
`endif
  output logic               cut
);

  logic hit;
  logic eff;

  // Inverted bounds (x1>x2 or y1>y2) naturally yield no hit.
  assign hit = cfg.en & (x >= cfg.x1) & (x <= cfg.x2) & (y >= cfg.y1) & (y <= cfg.y2);
  // en gates again so a disabled inverted slot does not cut everything.
  assign eff = cfg.en & (hit ^ cfg.inv);

`ifdef CUT_BLINK_EN
  assign cut = eff & ~(cfg.blink & blink_off);
`else
  assign cut = eff;
`endif

endmodule

// File: rtl/cut_bank.sv
// cut_bank: multi-region pipelined pixel cutter with double-buffered slot config.
//   clk, rst_n : pixel clock, async active-low reset
//   bus        : cut_bank_if.slave (config port, frame_start, pixel in/out)
// Fixed 2-cycle latency from pix_valid to out_valid; no back-pressure.
// Optional feature macro: CUT_BLINK_EN (per-slot blink driven by a 6-bit frame counter).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RUN    | config writes land in shadow slots; frame_start -> ST_COMMIT
// ST_COMMIT | cfg_ready low; shadow copied to active, back to ST_RUN
module cut_bank
  import cut_pkg::*;
#(
  parameter int NUM_RECT = 4
) (
  input logic     clk,
  input logic     rst_n,
  cut_bank_if.slave bus
);

  state_e    state_q, state_d;
  rect_cfg_t shadow_q [NUM_RECT];
  rect_cfg_t shadow_d [NUM_RECT];
  rect_cfg_t active_q [NUM_RECT];
  rect_cfg_t active_d [NUM_RECT];
  rect_cfg_t cfg_word;
  logic      cfg_fire;

  logic [NUM_RECT-1:0] cut_vec;
  logic [NUM_RECT-1:0] cut_s1_q, cut_s1_d;
  pixel_t              pix_s1_q, pix_s1_d;
  logic                vld_s1_q, vld_s1_d;
  pixel_t              rgbt_s2_q, rgbt_s2_d;
  logic                vld_s2_q, vld_s2_d;

`ifdef CUT_BLINK_EN
  logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    if (bus.frame_start) blink_cnt_d = blink_cnt_q + BLINK_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt_q <= '0;
    else        blink_cnt_q <= blink_cnt_d;
  end
`endif

  assign bus.cfg_ready = (state_q == ST_RUN);
  assign cfg_fire      = bus.cfg_valid & (state_q == ST_RUN);

  always_comb begin
    cfg_word     = '0;
    cfg_word.x1  = bus.cfg_x1;
    cfg_word.y1  = bus.cfg_y1;
    cfg_word.x2  = bus.cfg_x2;
    cfg_word.y2  = bus.cfg_y2;
    cfg_word.en  = bus.cfg_en;
    cfg_word.inv = bus.cfg_inv;
`ifdef CUT_BLINK_EN
    cfg_word.blink = bus.cfg_blink;
`endif
  end

  // A write coinciding with frame_start lands in shadow on the same edge,
  // so the following COMMIT already sees it.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    unique case (state_q)
      ST_RUN: begin
        if (cfg_fire && (int'(bus.cfg_idx) < NUM_RECT)) shadow_d[bus.cfg_idx] = cfg_word;
        if (bus.frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        active_d = shadow_q;
        state_d  = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  for (genvar i = 0; i < NUM_RECT; i++) begin : g_hit
    rect_hit u_hit (
      .cfg       (active_q[i]),
      .x         (bus.X),
      .y         (bus.Y),
`ifdef CUT_BLINK_EN
      .blink_off (blink_cnt_q[BLINK_CNT_W-1]),
`endif
      .cut       (cut_vec[i])
    );
  end

  always_comb begin
    cut_s1_d  = cut_vec;
    pix_s1_d  = pixel_t'(bus.layer_in);
    vld_s1_d  = bus.pix_valid;
    vld_s2_d  = vld_s1_q;
    rgbt_s2_d = rgbt_s2_q;
    if (vld_s1_q) begin
      if (|cut_s1_q) rgbt_s2_d = '{colour: '0, t: T_CLEAR};
      else           rgbt_s2_d = pix_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      for (int i = 0; i < NUM_RECT; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      cut_s1_q  <= '0;
      pix_s1_q  <= '0;
      vld_s1_q  <= 1'b0;
      rgbt_s2_q <= '0;
      vld_s2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cut_s1_q  <= cut_s1_d;
      pix_s1_q  <= pix_s1_d;
      vld_s1_q  <= vld_s1_d;
      rgbt_s2_q <= rgbt_s2_d;
      vld_s2_q  <= vld_s2_d;
    end
  end

  assign bus.out_valid = vld_s2_q;
  assign bus.rgbt_out  = rgbt_s2_q;

endmodule

// File: tb/tb_cut_bank.sv
module tb_cut_bank;

  logic clk;
  logic rst_n;

  cut_bank_if #(.NUM_RECT(4)) bus ();

  cut_bank #(.NUM_RECT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] exp;
    int         cyc;
    int         id;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  int  pix_id = 0;
  logic last_blink;

  // Advance to the next falling edge and check any pixel leaving the DUT.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    cyc++;
    if (bus.out_valid === 1'b1) begin
      tests++;
      assert (sb.size() != 0)
      else begin
        fails++;
        $error("FAIL spurious_out_valid: got out_valid=1 with %0d pending, required pending>0", sb.size());
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        assert (bus.rgbt_out === e.exp)
        else begin
          fails++;
          $error("FAIL pix%0d_rgbt: got %h required %h", e.id, bus.rgbt_out, e.exp);
        end
        tests++;
        assert (cyc === e.cyc)
        else begin
          fails++;
          $error("FAIL pix%0d_latency: got cycle %0d required %0d", e.id, cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_pix(input logic [9:0] x, input logic [9:0] y,
                          input logic [9:0] pix, input logic [9:0] exp);
    sb_t e;
    bus.pix_valid = 1'b1;
    bus.X         = x;
    bus.Y         = y;
    bus.layer_in  = pix;
    e.exp = exp;
    e.cyc = cyc + 2;
    e.id  = pix_id;
    pix_id++;
    sb.push_back(e);
    tick();
  endtask

  task automatic set_cfg(input logic [1:0] idx, input logic [9:0] x1, input logic [9:0] y1,
                         input logic [9:0] x2, input logic [9:0] y2,
                         input logic en, input logic inv, input logic blink);
    bus.cfg_idx = idx;
    bus.cfg_x1  = x1;
    bus.cfg_y1  = y1;
    bus.cfg_x2  = x2;
    bus.cfg_y2  = y2;
    bus.cfg_en  = en;
    bus.cfg_inv = inv;
    last_blink  = blink;
`ifdef CUT_BLINK_EN
    bus.cfg_blink = blink;
`endif
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [9:0] x1, input logic [9:0] y1,
                           input logic [9:0] x2, input logic [9:0] y2,
                           input logic en, input logic inv, input logic blink);
    set_cfg(idx, x1, y1, x2, y2, en, inv, blink);
    bus.cfg_valid = 1'b1;
    tests++;
    assert (bus.cfg_ready === 1'b1)
    else begin
      fails++;
      $error("FAIL cfg_ready_write: got %b required 1", bus.cfg_ready);
    end
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  // frame_start pulse (optionally with a simultaneous write already set up),
  // then check cfg_ready drops for the COMMIT cycle and comes back.
  task automatic frame_pulse(input logic with_write);
    bus.frame_start = 1'b1;
    bus.cfg_valid   = with_write;
    tests++;
    assert (bus.cfg_ready === 1'b1)
    else begin
      fails++;
      $error("FAIL cfg_ready_pre_frame: got %b required 1", bus.cfg_ready);
    end
    tick();
    bus.frame_start = 1'b0;
    bus.cfg_valid   = 1'b0;
    tests++;
    assert (bus.cfg_ready === 1'b0)
    else begin
      fails++;
      $error("FAIL cfg_ready_commit: got %b required 0", bus.cfg_ready);
    end
    tick();
    tests++;
    assert (bus.cfg_ready === 1'b1)
    else begin
      fails++;
      $error("FAIL cfg_ready_post_commit: got %b required 1", bus.cfg_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    bus.cfg_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.X           = '0;
    bus.Y           = '0;
    bus.layer_in    = '0;
    set_cfg(2'd0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

    tick();
    tick();
    tests++;
    assert (bus.cfg_ready === 1'b1) else begin fails++; $error("FAIL reset_cfg_ready: got %b required 1", bus.cfg_ready); end
    tests++;
    assert (bus.out_valid === 1'b0) else begin fails++; $error("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    tests++;
    assert (bus.rgbt_out === 10'h000) else begin fails++; $error("FAIL reset_rgbt: got %h required 000", bus.rgbt_out); end
    rst_n = 1'b1;
    tick();

    // No slots enabled: pass-through, 2-cycle latency.
    send_pix(10'd100, 10'd100, 10'h3FF, 10'h3FF);
    send_pix(10'd100, 10'd100, 10'h3FF, 10'h3FF);
    send_pix(10'd100, 10'd100, 10'h3FF, 10'h3FF);
    idle(4);

    // Shadow write not visible until frame start.
    cfg_write(2'd0, 10'd10, 10'd10, 10'd20, 10'd20, 1'b1, 1'b0, 1'b0);
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h3FF);
    idle(3);
    frame_pulse(1'b0);
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h000);
    send_pix(10'd21, 10'd15, 10'h3FF, 10'h3FF);
    send_pix(10'd10, 10'd10, 10'h2A5, 10'h000);
    send_pix(10'd20, 10'd21, 10'h2A4, 10'h2A4);
    idle(3);

    // 1x1 slot and an x1>x2 slot that must never cut.
    cfg_write(2'd1, 10'd5, 10'd5, 10'd5, 10'd5, 1'b1, 1'b0, 1'b0);
    cfg_write(2'd3, 10'd30, 10'd0, 10'd20, 10'd479, 1'b1, 1'b0, 1'b0);
    frame_pulse(1'b0);
    send_pix(10'd5, 10'd5, 10'h155, 10'h000);
    send_pix(10'd5, 10'd6, 10'h155, 10'h155);
    send_pix(10'd4, 10'd5, 10'h0F1, 10'h0F1);
    send_pix(10'd6, 10'd5, 10'h0F0, 10'h0F0);
    send_pix(10'd25, 10'd100, 10'h3FF, 10'h3FF);
    idle(3);

    // Slot0 inverted: keep only its inside.
    cfg_write(2'd0, 10'd10, 10'd10, 10'd20, 10'd20, 1'b1, 1'b1, 1'b0);
    frame_pulse(1'b0);
    send_pix(10'd0, 10'd0, 10'h3FF, 10'h000);
    send_pix(10'd10, 10'd20, 10'h2B7, 10'h2B7);
    send_pix(10'd20, 10'd10, 10'h1C2, 10'h1C2);
    send_pix(10'd9, 10'd15, 10'h3FF, 10'h000);
    idle(3);

    // Write and frame_start in the same cycle: write lands and is committed.
    set_cfg(2'd2, 10'd0, 10'd0, 10'd639, 10'd479, 1'b1, 1'b0, 1'b0);
    frame_pulse(1'b1);
    send_pix(10'd300, 10'd200, 10'h3FF, 10'h000);
    send_pix(10'd639, 10'd479, 10'h1FF, 10'h000);
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h000);
    idle(3);

    // Mid-frame reset: active slots cleared, output pass-through.
    rst_n = 1'b0;
    tick();
    tests++;
    assert (bus.out_valid === 1'b0) else begin fails++; $error("FAIL midreset_out_valid: got %b required 0", bus.out_valid); end
    tests++;
    assert (bus.rgbt_out === 10'h000) else begin fails++; $error("FAIL midreset_rgbt: got %h required 000", bus.rgbt_out); end
    rst_n = 1'b1;
    tick();
    send_pix(10'd300, 10'd200, 10'h3FF, 10'h3FF);
    idle(3);
    frame_pulse(1'b0);
    send_pix(10'd15, 10'd15, 10'h2A5, 10'h2A5);
    idle(3);

`ifdef CUT_BLINK_EN
    // Counter was reset to 0 and advanced once by the commit above (now 1).
    cfg_write(2'd0, 10'd10, 10'd10, 10'd20, 10'd20, 1'b1, 1'b0, 1'b1);
    frame_pulse(1'b0);                          // counter 2
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h000);
    idle(3);
    for (int f = 0; f < 29; f++) frame_pulse(1'b0); // counter 31
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h000);
    idle(3);
    frame_pulse(1'b0);                          // counter 32
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h3FF);
    idle(3);
    for (int f = 0; f < 31; f++) frame_pulse(1'b0); // counter 63
    send_pix(10'd15, 10'd15, 10'h2A5, 10'h2A5);
    idle(3);
    frame_pulse(1'b0);                          // counter wraps to 0
    send_pix(10'd15, 10'd15, 10'h3FF, 10'h000);
    idle(3);
`endif

    idle(4);
    tests++;
    assert (sb.size() == 0)
    else begin
      fails++;
      $error("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cut_bank.md
Name: cut_bank

Overview:
- Multi-region, pipelined cutter for the VGA layer compositor; a successor to the single-rectangle combinational cut.
- Holds NUM_RECT programmable rectangles.
- Each region either cuts its inside or keeps only its inside. A cut pixel is made transparent: colour zeroed, t-bit cleared.
- Region config is double-buffered and takes effect only at frame start, so there is no tearing mid-frame.

Parameters:
- COORD_W, 10, coordinate width for X/Y and rectangle bounds
- COLOR_W, 9, colour bits in a pixel; the pixel is COLOR_W+1 bits with the t-bit at bit 0 (1 = opaque)
- NUM_RECT, 4, number of rectangle slots (1..16)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_idx  in  $clog2(NUM_RECT) max 1  slot index
- cfg_x1, cfg_y1, cfg_x2, cfg_y2  in  COORD_W each  inclusive bounds
- cfg_en  in  1  slot enable
- cfg_inv  in  1  0 = cut inside, 1 = cut outside
- frame_start  in  1  one-cycle pulse at start of frame
- pix_valid  in  1  pixel qualifier
- X, Y  in  COORD_W  current pixel coordinate
- layer_in  in  COLOR_W+1  {colour, t}
- out_valid  out  1  pixel qualifier, delayed by 2
- rgbt_out  out  COLOR_W+1  cut result

Behaviour:
- Reset:
  - Shadow and active slots all cleared, en=0.
  - cfg_ready=1, out_valid=0, rgbt_out=0, pipeline valids=0.
- Config port:
  - A write on valid&ready stores cfg_* into shadow slot cfg_idx.
  - cfg_idx >= NUM_RECT: the write is accepted and dropped.
- FSM with states RUN and COMMIT:
  - RUN, frame_start=1: go to COMMIT and deassert cfg_ready.
  - COMMIT: copy all shadow slots to active in one cycle, then return to RUN with cfg_ready=1.
  - frame_start together with cfg_valid in RUN: the write is accepted first. Shadow is updated that edge; COMMIT copies the new value.
  - frame_start while in COMMIT is ignored.
- Hit test, per active slot: hit = en & (x1<=X<=x2) & (y1<=Y<=y2), unsigned, inclusive.
  - x1>x2 or y1>y2 gives no hit.
  - A degenerate 1x1 rectangle (x1=x2, y1=y2) hits exactly one pixel.
- Effective cut, per slot: cut_i = en & (hit ^ inv).
- Pixel cut = OR over all cut_i.
- Pipeline, 2 cycles fixed latency:
  - S1 registers per-slot cut_i, layer_in and pix_valid.
  - S2 registers the OR reduction and the output.
- Output when cut: rgbt_out = 0, i.e. colour zeroed and t=0.
- Output when not cut: rgbt_out = layer_in, passed through unchanged (including t).
- No back-pressure on the pixel path.
  - rgbt_out updates only when the stage is valid.
  - out_valid mirrors pix_valid delayed by 2.
- Active slots are used for every pixel. A commit in cycle N affects pixels sampled at S1 in cycle N+1 and later.
- rst_n asserted mid-frame: everything clears immediately, including active slots, so all output is pass-through.

Optional Feature:
- Macro CUT_BLINK_EN.
  - When defined: each slot gains a cfg_blink input bit, stored and committed with the slot. A 6-bit frame counter increments on each frame_start (wraps 63->0, reset 0). A slot with blink=1 has cut_i forced to 0 while counter[5]=1, so it blinks with a 64-frame period.
  - When undefined: no cfg_blink port, no counter, and behaviour is exactly as above.

Decomposition:
- Shared package cut_pkg:
  - pixel struct typedef {colour[COLOR_W-1:0], t}
  - rect_cfg_t {x1,y1,x2,y2,en,inv[,blink]}
  - constants T_OPAQUE=1, T_CLEAR=0, BLINK_CNT_W=6
- One sub-module, rect_hit: combinational per-slot inclusive bounds test plus inv/en logic, instantiated NUM_RECT times.

Test Plan:
- Reset, then drive X=100, Y=100, layer_in=10'h3FF with pix_valid for 3 cycles. Required: out_valid high on cycle 2, rgbt_out=10'h3FF (no slots enabled).
- Write slot0 (10,10)-(20,20), en=1, inv=0, with no frame_start. Pixel (15,15) must still return 10'h3FF. Pulse frame_start, wait 2 cycles; (15,15) must return 10'h000 and (21,15) must return 10'h3FF.
- Slot1 (5,5)-(5,5), inv=0, committed. (5,5) returns 0; (5,6) and (4,5) pass through. Slot with x1=30, x2=20 never cuts.
- Slot0 inv=1 (10,10)-(20,20), committed. (0,0) returns 0; (10,20) passes through unchanged.
- frame_start and cfg_valid in the same cycle writing slot2 (0,0)-(639,479). The write is accepted, cfg_ready is low the next cycle, and every pixel afterwards returns 0.
- CUT_BLINK_EN: slot0 blink=1 covering (15,15). For frames 0-31 the pixel returns 0; frames 32-63 return layer_in; frame 64 returns 0 again.
